transaction_merge: RTL

- Transmit-side counterpart of the transfer layer: drains the four per-class output FIFOs (P0..P3) and merges them into a single outbound word stream.
- Pops the FIFOs under round-robin arbitration and honours downstream almost-full backpressure.
- Keeps per-port forwarded-word counters, read out through the req/idx/counterValid/counterOut interface already used by the transfer layer.

---
 rtl/transaction_merge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/transaction_merge.sv
// rtl/transaction_merge.sv - round-robin merge of four class FIFOs into one outbound word stream
module transaction_merge #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  emptyP0,
  input  logic                  emptyP1,
  input  logic                  emptyP2,
  input  logic                  emptyP3,
  input  logic [DATA_WIDTH-1:0] dataInP0,
  input  logic [DATA_WIDTH-1:0] dataInP1,
  input  logic [DATA_WIDTH-1:0] dataInP2,
  input  logic [DATA_WIDTH-1:0] dataInP3,
  output logic                  popP0,
  output logic                  popP1,
  output logic                  popP2,
  output logic                  popP3,
  input  logic                  almostFull,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  pushOut,
  input  logic                  req,
  input  logic [2:0]            idx,
  output logic                  counterValid,
  output logic [CNT_WIDTH-1:0]  counterOut,
  output logic                  idle
);

  typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;

  state_t                state;
  logic [1:0]            ptr;
  logic [3:0]            pop_q;
  logic [1:0]            pop_tag;
  logic                  s2_valid;
  logic                  s2_count;
  logic [1:0]            s2_tag;
  logic [CNT_WIDTH-1:0]  cnt [4];

  logic [3:0]            empty_v;
  logic                  gnt_any;
  logic [1:0]            gnt_idx;
  logic [1:0]            cand;
  logic                  grant;
  logic                  kill;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] data_sel;

  assign empty_v   = {emptyP3, emptyP2, emptyP1, emptyP0};
  assign {popP3, popP2, popP1, popP0} = pop_q;
  assign in_flight = (|pop_q) | s2_valid;
  assign grant     = (state == S_ACTIVE) & ~init & ~almostFull & gnt_any;
  // Words still in the pipe when init lands are pushed but must not be counted.
  assign kill      = (state == S_INIT) |
                     (init & ((state == S_IDLE) | (state == S_ACTIVE)));

  // Search ptr+1 .. ptr; the last candidate wraps back onto ptr itself.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!gnt_any && !empty_v[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    case (s2_tag)
      2'd0:    data_sel = dataInP0;
      2'd1:    data_sel = dataInP1;
      2'd2:    data_sel = dataInP2;
      default: data_sel = dataInP3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_RESET;
      ptr          <= 2'd3;
      pop_q        <= '0;
      pop_tag      <= '0;
      s2_valid     <= 1'b0;
      s2_count     <= 1'b0;
      s2_tag       <= '0;
      dataOut      <= '0;
      pushOut      <= 1'b0;
      counterValid <= 1'b0;
      counterOut   <= '0;
      idle         <= 1'b0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      pop_q <= '0;
      if (grant) begin
        pop_q   <= 4'b0001 << gnt_idx;
        pop_tag <= gnt_idx;
        ptr     <= gnt_idx;
      end

      // FIFO read data lands one cycle after the pop, so the tag trails by one stage.
      s2_valid <= |pop_q;
      s2_count <= (|pop_q) & ~kill;
      s2_tag   <= pop_tag;
      pushOut  <= s2_valid;
      if (s2_valid) dataOut <= data_sel;

      if (state == S_INIT) begin
        ptr <= 2'd3;
        for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else if (s2_valid && s2_count && !kill) begin
        cnt[s2_tag] <= cnt[s2_tag] + CNT_WIDTH'(1);
      end

      counterValid <= req;
      if (req) counterOut <= idx[2] ? '0 : cnt[idx[1:0]];

      case (state)
        S_RESET: state <= S_INIT;
        S_INIT: begin
          if (!init) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        end
        S_IDLE: begin
          if (init) begin
            state <= S_INIT;
            idle  <= 1'b0;
          end else if (!(&empty_v)) begin
            state <= S_ACTIVE;
            idle  <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (init) begin
            state <= S_INIT;
          end else if ((&empty_v) && !in_flight) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule
